// File: rtl/median_pkg.sv
// Shared definitions for the median_sort_n order-statistic filter:
// FSM state encoding, default geometry and the rank clamp helper.
package median_pkg;

    // Frame phases: collect samples, sort in place, present the result
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Default window length (odd, >= 3) and sample width
    localparam int DEFAULT_N      = 9;
    localparam int DEFAULT_DATA_W = 8;

    // Requested ranks past the end of the window select the maximum
    function automatic int unsigned clamp_rank(input int unsigned rank, input int unsigned n);
        return (rank >= n) ? (n - 1) : rank;
    endfunction

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-exchange cell used by the odd-even transposition sort.
// The pair is swapped only when the lower-index value is strictly larger, so
// equal values keep their order.
module cmp_swap
    import median_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    logic swap;

    assign swap = (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/median_sort_n.sv
// Parametrised order-statistic filter.
// Collects N unsigned samples over a ready/valid port, sorts them in place
// with one odd-even transposition pass per clock, then presents the selected
// rank (latched with the first sample of the frame) on a ready/valid port.
// Optional feature macro: MEDIAN_SORT_MINMAX_EN adds out_min / out_max.
module median_sort_n
    import median_pkg::*;
#(
    parameter  int N      = DEFAULT_N,
    parameter  int DATA_W = DEFAULT_DATA_W,
    localparam int RANK_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in,
    output logic              in_ready,
    input  logic [RANK_W-1:0] rank_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out
`ifdef MEDIAN_SORT_MINMAX_EN
    ,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max
`endif
);

    // Compare-exchange cells: floor(N/2) is enough for both pass parities
    localparam int                PAIRS    = N / 2;
    localparam logic [RANK_W-1:0] LAST_IDX = RANK_W'(N - 1);

    state_t            state;
    logic [RANK_W-1:0] sample_cnt;
    logic [RANK_W-1:0] pass_cnt;
    logic [RANK_W-1:0] rank_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_q;
`ifdef MEDIAN_SORT_MINMAX_EN
    logic [DATA_W-1:0] out_min_q;
    logic [DATA_W-1:0] out_max_q;
`endif

    logic [DATA_W-1:0] win      [N];
    logic [DATA_W-1:0] win_next [N];

    logic [DATA_W-1:0] pair_a  [PAIRS];
    logic [DATA_W-1:0] pair_b  [PAIRS];
    logic [DATA_W-1:0] pair_lo [PAIRS];
    logic [DATA_W-1:0] pair_hi [PAIRS];

    logic odd_pass;
    logic last_pass;
    logic last_sample;
    logic accept;

    assign odd_pass    = pass_cnt[0];
    assign last_pass   = (pass_cnt == LAST_IDX);
    assign last_sample = (sample_cnt == LAST_IDX);
    // in_ready_q is only ever set while in LOAD, so it doubles as the LOAD flag
    assign accept      = in_valid && in_ready_q;

    // Even passes pair (0,1),(2,3)..; odd passes pair (1,2),(3,4)..
    // With N odd, the highest odd-pass pair is (N-2, N-1), so 2k+2 stays in range.
    for (genvar k = 0; k < PAIRS; k++) begin : g_pair
        assign pair_a[k] = odd_pass ? win[2*k+1] : win[2*k];
        assign pair_b[k] = odd_pass ? win[2*k+2] : win[2*k+1];

        cmp_swap #(
            .DATA_W (DATA_W)
        ) u_cmp_swap (
            .a  (pair_a[k]),
            .b  (pair_b[k]),
            .lo (pair_lo[k]),
            .hi (pair_hi[k])
        );
    end

    // Window contents after applying the current pass; untouched slots pass through
    always_comb begin
        // NOTE: every slot gets a default before the conditional writes, so no latch is inferred.
        for (int i = 0; i < N; i++) begin
            win_next[i] = win[i];
        end
        for (int k = 0; k < PAIRS; k++) begin
            if (odd_pass) begin
                win_next[2*k+1] = pair_lo[k];
                win_next[2*k+2] = pair_hi[k];
            end else begin
                win_next[2*k]   = pair_lo[k];
                win_next[2*k+1] = pair_hi[k];
            end
        end
    end

    // Window registers: shift in on accept, rewrite in place during SORT
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the window is a register array, not RAM, and is cleared on reset so a frame never sees stale data.
            for (int i = 0; i < N; i++) begin
                win[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < N - 1; i++) begin
                win[i] <= win[i+1];
            end
            win[N-1] <= in;
        end else if (state == SORT) begin
            for (int i = 0; i < N; i++) begin
                win[i] <= win_next[i];
            end
        end
    end

    // Frame FSM with counters, rank latch and registered handshake outputs
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
        if (rst) begin
            state       <= LOAD;
            sample_cnt  <= '0;
            pass_cnt    <= '0;
            rank_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
`ifdef MEDIAN_SORT_MINMAX_EN
            out_min_q   <= '0;
            out_max_q   <= '0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (sample_cnt == '0) begin
                            rank_q <= RANK_W'(clamp_rank(32'(rank_sel), N));
                        end
                        if (last_sample) begin
                            state      <= SORT;
                            sample_cnt <= '0;
                            pass_cnt   <= '0;
                            in_ready_q <= 1'b0;
                        end else begin
                            sample_cnt <= sample_cnt + RANK_W'(1);
                        end
                    end
                end

                SORT: begin
                    if (last_pass) begin
                        // Capture from the final pass so the result is valid on entry to OUT
                        state       <= OUT;
                        pass_cnt    <= '0;
                        out_valid_q <= 1'b1;
                        out_q       <= win_next[rank_q];
`ifdef MEDIAN_SORT_MINMAX_EN
                        out_min_q   <= win_next[0];
                        out_max_q   <= win_next[N-1];
`endif
                    end else begin
                        pass_cnt <= pass_cnt + RANK_W'(1);
                    end
                end

                OUT: begin
                    if (out_valid_q && out_ready) begin
                        state       <= LOAD;
                        sample_cnt  <= '0;
                        pass_cnt    <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state       <= LOAD;
                    sample_cnt  <= '0;
                    pass_cnt    <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // Handshake outputs are forced idle while reset is held
    assign in_ready  = in_ready_q && !rst;
    assign out_valid = out_valid_q && !rst;
    assign out       = rst ? '0 : out_q;
`ifdef MEDIAN_SORT_MINMAX_EN
    assign out_min   = rst ? '0 : out_min_q;
    assign out_max   = rst ? '0 : out_max_q;
`endif

endmodule

// File: tb/tb_median_sort_n.sv
// Self-checking bench for median_sort_n: a 9 x 8-bit instance exercises the
// frame protocol, and a 5 x 12-bit instance covers rank clamping (plus
// out_min / out_max when MEDIAN_SORT_MINMAX_EN is defined).
module tb_median_sort_n;

    localparam int N  = 9;
    localparam int W  = 8;
    localparam int N2 = 5;
    localparam int W2 = 12;

    typedef logic [15:0] frame_t [9];

    logic          clk = 1'b0;
    logic          rst;

    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic [3:0]    rank_sel;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    logic          in2_valid;
    logic [W2-1:0] in2_data;
    logic          in2_ready;
    logic [2:0]    rank2;
    logic          out2_valid;
    logic          out2_ready;
    logic [W2-1:0] out2_data;
`ifdef MEDIAN_SORT_MINMAX_EN
    logic [W-1:0]  min1;
    logic [W-1:0]  max1;
    logic [W2-1:0] min2;
    logic [W2-1:0] max2;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [15:0]   exp_q [$];

    always #5 clk = ~clk;

    median_sort_n #(.N(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in_data),
        .in_ready  (in_ready),
        .rank_sel  (rank_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_data)
`ifdef MEDIAN_SORT_MINMAX_EN
        ,
        .out_min   (min1),
        .out_max   (max1)
`endif
    );

    median_sort_n #(.N(N2), .DATA_W(W2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in2_valid),
        .in        (in2_data),
        .in_ready  (in2_ready),
        .rank_sel  (rank2),
        .out_valid (out2_valid),
        .out_ready (out2_ready),
        .out       (out2_data)
`ifdef MEDIAN_SORT_MINMAX_EN
        ,
        .out_min   (min2),
        .out_max   (max2)
`endif
    );

    // Reference order statistic: sort the first n entries, clamp the rank
    function automatic logic [15:0] model_rank(input frame_t s, input int n, input int r);
        frame_t      t;
        logic [15:0] tmp;
        t = s;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n - 1 - i; j++) begin
                if (t[j] > t[j+1]) begin
                    tmp    = t[j];
                    t[j]   = t[j+1];
                    t[j+1] = tmp;
                end
            end
        end
        if (r >= n) r = n - 1;
        return t[r];
    endfunction

    // Drive one frame into dut; rank only meaningful with the first sample.
    // gap = idle cycles before each sample; keep_valid leaves junk valid afterwards.
    task automatic send_frame(input frame_t s, input logic [3:0] r, input int gap, input bit keep_valid);
        int t;
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = s[i][W-1:0];
            rank_sel = (i == 0) ? r : 4'($urandom_range(0, 15));
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL send_frame: in_ready stuck low, got %0b required 1", in_ready);
            end
            @(negedge clk);
        end
        if (keep_valid) begin
            in_data  = 8'hFF;
            rank_sel = 4'd0;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Wait for out_valid (counting cycles from the last accept), then pop and compare
    task automatic wait_result(input string name, output int lat);
        logic [15:0] exp;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s_valid: out_valid got %0b required 1", name, out_valid);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_queue: result got %0d with no expected entry", name, out_data);
        end else begin
            exp = exp_q.pop_front();
            if ({8'h00, out_data} !== exp) begin
                errors++;
                $display("FAIL %s_out: got %0d required %0d", name, out_data, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        rank_sel   = '0;
        out_ready  = 1'b1;
        in2_valid  = 1'b0;
        in2_data   = '0;
        rank2      = '0;
        out2_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%0b valid=%0b out=%0d required 0 0 0",
                     in_ready, out_valid, out_data);
        end
        checks++;
        if (in2_ready !== 1'b0 || out2_valid !== 1'b0 || out2_data !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs2: got ready=%0b valid=%0b out=%0d required 0 0 0",
                     in2_ready, out2_valid, out2_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready got %0b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        frame_t f;
        int     lat;
        f = '{16'd9, 16'd1, 16'd8, 16'd2, 16'd7, 16'd3, 16'd6, 16'd4, 16'd5};
        exp_q.push_back(16'd5);
        send_frame(f, 4'd4, 0, 1'b0);
        wait_result("basic", lat);
        checks++;
        if (lat !== N + 1) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles required %0d", lat, N + 1);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: got valid=%0b ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_duplicates();
        frame_t     f;
        int         lat;
        logic [3:0] ranks [3];
        logic [15:0] exps [3];
        f     = '{16'd3, 16'd3, 16'd3, 16'd0, 16'd0, 16'd255, 16'd255, 16'd3, 16'd0};
        ranks = '{4'd0, 4'd4, 4'd8};
        exps  = '{16'd0, 16'd3, 16'd255};
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(exps[k]);
            send_frame(f, ranks[k], 0, 1'b0);
            wait_result("dup", lat);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        frame_t     f;
        int         lat;
        logic [7:0] held;
        bit         bad;
        f = '{16'd9, 16'd1, 16'd8, 16'd2, 16'd7, 16'd3, 16'd6, 16'd4, 16'd5};
        out_ready = 1'b0;
        exp_q.push_back(16'd5);
        send_frame(f, 4'd4, 0, 1'b0);
        wait_result("hold", lat);
        held = out_data;
        bad  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold_stable: got valid=%0b out=%0d ready=%0b required 1 %0d 0",
                     out_valid, out_data, in_ready, held);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got valid=%0b ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_gaps();
        frame_t f;
        int     lat;
        f = '{16'd9, 16'd1, 16'd8, 16'd2, 16'd7, 16'd3, 16'd6, 16'd4, 16'd5};
        exp_q.push_back(16'd5);
        send_frame(f, 4'd4, 2, 1'b1);
        wait_result("gaps", lat);
        checks++;
        if (lat !== N + 1) begin
            errors++;
            $display("FAIL gaps_latency: got %0d cycles required %0d", lat, N + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        frame_t f;
        int     lat;
        bit     seen;
        f = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        send_frame(f, 4'd4, 0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'd0) begin
            errors++;
            $display("FAIL abort_reset: got ready=%0b valid=%0b out=%0d required 0 0 0",
                     in_ready, out_valid, out_data);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2 * N + 4; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_result: out_valid got 1 required 0");
        end
        for (int i = 0; i < N; i++) f[i] = 16'h0080;
        exp_q.push_back(16'h0080);
        send_frame(f, 4'd4, 0, 1'b0);
        wait_result("abort_next", lat);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        frame_t     f;
        int         lat;
        logic [3:0] r;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) f[i] = 16'($urandom_range(0, 255));
            r = 4'($urandom_range(0, 12));
            exp_q.push_back(model_rank(f, N, int'(r)));
            send_frame(f, r, 0, 1'b0);
            wait_result("b2b", lat);
            @(negedge clk);
        end
    endtask

    task automatic test_param();
        frame_t      f;
        int          lat;
        int          t;
        logic [15:0] exp;
        f = '{16'd4095, 16'd0, 16'd100, 16'd2048, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
        exp_q.push_back(16'd4095);
        for (int i = 0; i < N2; i++) begin
            in2_valid = 1'b1;
            in2_data  = f[i][W2-1:0];
            rank2     = (i == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            t = 0;
            while (!in2_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!in2_ready) begin
                checks++;
                errors++;
                $display("FAIL param_ready: in_ready got %0b required 1", in2_ready);
            end
            @(negedge clk);
        end
        in2_valid = 1'b0;
        lat = 1;
        while (!out2_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== N2 + 1) begin
            errors++;
            $display("FAIL param_latency: got %0d cycles required %0d", lat, N2 + 1);
        end
        checks++;
        exp = exp_q.pop_front();
        if ({4'h0, out2_data} !== exp) begin
            errors++;
            $display("FAIL param_clamp: got %0d required %0d", out2_data, exp);
        end
`ifdef MEDIAN_SORT_MINMAX_EN
        checks++;
        if (min2 !== 12'd0 || max2 !== 12'd4095) begin
            errors++;
            $display("FAIL param_minmax: got min=%0d max=%0d required 0 4095", min2, max2);
        end
`endif
        @(negedge clk);
        checks++;
        if (out2_valid !== 1'b0) begin
            errors++;
            $display("FAIL param_release: out_valid got %0b required 0", out2_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duplicates();
        test_backpressure();
        test_gaps();
        test_abort();
        test_back_to_back();
        test_param();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
